wl_access_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the 1x16 word-line demux pair (32 words: ADR4 + ADR[3:0]).

---
 rtl/wl_access_ctrl_if.sv | 36 +++
 rtl/wl_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_wl_access_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/wl_access_ctrl_if.sv
// Bus between the word-line requesters and the access controller.
//  req       2  level request, one bit per requester
//  req_adr0  5  requester 0 word address {adr4, adr}
//  req_adr1  5  requester 1 word address {adr4, adr}
//  req_we    2  per-requester write(1)/read(0) qualifier
//  gnt       2  one-hot grant pulse
//  ack       2  one-hot completion pulse
//  in        1  demux data/enable input
//  adr4      1  demux upper address bit
//  adr       4  demux lower address
//  we        1  array write enable
//  busy      1  controller not idle
// The master modport belongs to the requester side; the controller uses slave.
interface wl_access_ctrl_if;
  logic [1:0] req;
  logic [4:0] req_adr0;
  logic [4:0] req_adr1;
  logic [1:0] req_we;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic       in;
  logic       adr4;
  logic [3:0] adr;
  logic       we;
  logic       busy;

  modport master (
    output req, req_adr0, req_adr1, req_we,
    input  gnt, ack, in, adr4, adr, we, busy
  );

  modport slave (
    input  req, req_adr0, req_adr1, req_we,
    output gnt, ack, in, adr4, adr, we, busy
  );
endinterface

// File: rtl/wl_access_ctrl.sv
// Round-robin sequencer in front of the 1x16 word-line demux pair (32 words).
// Each granted access drives the demux address, then a SETUP / PULSE / HOLD sequence on
// `in`, so the address is always stable while `in` is high.
//  clk   1  clock, rising edge
//  rst   1  synchronous reset, active-high
//  bus   wl_access_ctrl_if.slave: requests in, grant/ack/demux controls out
// All outputs are registered.
module wl_access_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  wl_access_ctrl_if.slave  bus
);

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("wl_access_ctrl: SETUP_CYC must be in 1..15");
  end
  if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
    $error("wl_access_ctrl: PULSE_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_hold
    $error("wl_access_ctrl: HOLD_CYC must be in 1..15");
  end

  // Counter load values: phase lasts load+1 cycles, exits when the counter reads 0.
  localparam logic [3:0] SetupLd = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PulseLd = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HoldLd  = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       own_q, own_d;   // requester of the current/most recent access
  logic       wr_q, wr_d;     // latched write flag
  logic [4:0] adr_q, adr_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] ack_q, ack_d;
  logic       in_q, in_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       win;
  logic [1:0] own_oh;

  assign own_oh = {own_q, ~own_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    gnt_d   = 2'b00;
    ack_d   = 2'b00;
    in_d    = 1'b0;
    we_d    = 1'b0;
    win     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          // On a tie the requester not granted last wins.
          win     = (bus.req == 2'b11) ? ~own_q : bus.req[1];
          state_d = StSetup;
          cnt_d   = SetupLd;
          own_d   = win;
          wr_d    = bus.req_we[win];
          adr_d   = win ? bus.req_adr1 : bus.req_adr0;
          gnt_d   = {win, ~win};
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
          in_d    = 1'b1;
          we_d    = wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPulse: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          // Single-cycle HOLD: that cycle is also the ack cycle.
          if (HoldLd == 4'd0) ack_d = own_oh;
        end else begin
          cnt_d = cnt_q - 4'd1;
          in_d  = 1'b1;
          we_d  = wr_q;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) ack_d = own_oh;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      own_q   <= 1'b1;  // "last granted = 1" so requester 0 wins the first tie
      wr_q    <= 1'b0;
      adr_q   <= 5'd0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      in_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      in_q    <= in_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.in   = in_q;
  assign bus.we   = we_q;
  assign bus.busy = busy_q;
  assign bus.adr4 = adr_q[4];
  assign bus.adr  = adr_q[3:0];

endmodule

// File: tb/tb_wl_access_ctrl.sv
// Directed bench for wl_access_ctrl. Each access pushes its expected winner, address and
// write flag to a scoreboard queue; the entry is popped at the grant and used to check
// every cycle of the access against the SETUP/PULSE/HOLD timing.
module tb_wl_access_ctrl;

  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;
  localparam int T = S + P + H;

  typedef struct {
    int         w;
    logic [4:0] a;
    logic       wr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  wl_access_ctrl_if bus ();

  wl_access_ctrl #(
    .SETUP_CYC(S),
    .PULSE_CYC(P),
    .HOLD_CYC (H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_in"}, 32'(bus.in), 32'd0);
    chk({tag, "_we"}, 32'(bus.we), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_adr"}, 32'({bus.adr4, bus.adr}), 32'd0);
  endtask

  // Starts one access from IDLE and checks cycles 1..T+1. After the grant edge the
  // requests are changed to rq_after and the address/write inputs are scrambled; the
  // access in flight must not notice.
  task automatic do_access(input logic [1:0] rq, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [1:0] wev, input logic [1:0] rq_after, input int w);
    exp_t       e;
    logic [1:0] oh;
    logic       in_e;
    bus.req      = rq;
    bus.req_adr0 = a0;
    bus.req_adr1 = a1;
    bus.req_we   = wev;
    e.w  = w;
    e.a  = (w == 1) ? a1 : a0;
    e.wr = wev[w];
    sb.push_back(e);
    step();
    bus.req      = rq_after;
    bus.req_adr0 = a0 ^ 5'h13;
    bus.req_adr1 = a1 ^ 5'h0b;
    bus.req_we   = ~wev;
    e  = sb.pop_front();
    oh = (e.w == 1) ? 2'b10 : 2'b01;
    for (int c = 1; c <= T + 1; c++) begin
      if (c > 1) step();
      in_e = (c >= S + 1) && (c <= S + P);
      chk("gnt", 32'(bus.gnt), (c == 1) ? 32'(oh) : 32'd0);
      chk("ack", 32'(bus.ack), (c == T) ? 32'(oh) : 32'd0);
      chk("in", 32'(bus.in), 32'(in_e));
      chk("we", 32'(bus.we), 32'(in_e & e.wr));
      chk("adr", 32'({bus.adr4, bus.adr}), 32'(e.a));
      chk("busy", 32'(bus.busy), (c <= T) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic reset_pulse();
    rst     = 1'b1;
    bus.req = 2'b00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = 2'b11;
    bus.req_adr0 = 5'h0f;
    bus.req_adr1 = 5'h11;
    bus.req_we   = 2'b11;
    @(negedge clk);

    // Reset held with both requesting: nothing may be granted.
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all_zero("rst");
    end
    rst     = 1'b0;
    bus.req = 2'b00;
    step();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Single write by requester 0 to word 0x13.
    do_access(2'b01, 5'h13, 5'h00, 2'b01, 2'b00, 0);

    // Both requesting continuously from reset: alternate 0,1,0,1 with one idle gap.
    reset_pulse();
    do_access(2'b11, 5'h05, 5'h1a, 2'b10, 2'b11, 0);
    do_access(2'b11, 5'h05, 5'h1a, 2'b10, 2'b11, 1);
    do_access(2'b11, 5'h05, 5'h1a, 2'b10, 2'b11, 0);
    do_access(2'b11, 5'h05, 5'h1a, 2'b10, 2'b00, 1);

    // Requester 1 sweeps every word, read then write.
    for (int a = 0; a < 32; a++) begin
      for (int wr = 0; wr < 2; wr++) begin
        do_access(2'b10, 5'h00, 5'(a), {1'(wr), 1'b0}, 2'b00, 1);
      end
    end

    // Reset in the first PULSE cycle aborts the access without an ack.
    bus.req      = 2'b01;
    bus.req_adr0 = 5'h13;
    bus.req_we   = 2'b01;
    step();
    chk("abort_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    step();
    chk("abort_in_pre", 32'(bus.in), 32'd1);
    chk("abort_we_pre", 32'(bus.we), 32'd1);
    rst = 1'b1;
    step();
    chk_all_zero("abort");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_noack", 32'(bus.ack), 32'd0);
      chk("abort_idle", 32'(bus.busy), 32'd0);
    end
    // Requester 0 was granted last, but the reset restores its priority.
    do_access(2'b11, 5'h07, 5'h18, 2'b00, 2'b00, 0);

    // Drop request and move req_adr0 to 0 right after the grant.
    do_access(2'b01, 5'h13, 5'h04, 2'b00, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nogrant", 32'(bus.gnt), 32'd0);
      chk("adr_kept", 32'({bus.adr4, bus.adr}), 32'h13);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
